// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the data-RAM slave port.
// Read returns are steered back to the issuing master by a tag pipe.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_we,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_we,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] s_waddr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_we,
  output logic [ADDR_W-1:0] s_raddr,
  input  logic [DATA_W-1:0] s_rdata
);

  logic              last_gnt;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_o;
  logic              rd_fire;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (m0_req && m1_req) begin
      if (FIXED_PRIO != 0 || last_gnt)
        m0_gnt = 1'b1;
      else
        m1_gnt = 1'b1;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  // Idle cycles drive zeros so the RAM never sees a stray write.
  always_comb begin
    sel_addr = '0;
    s_wdata  = '0;
    s_we     = 4'h0;
    unique case (1'b1)
      m0_gnt: begin
        sel_addr = m0_addr;
        s_wdata  = m0_wdata;
        s_we     = m0_we;
      end
      m1_gnt: begin
        sel_addr = m1_addr;
        s_wdata  = m1_wdata;
        s_we     = m1_we;
      end
      default: ;
    endcase
  end

  assign s_waddr = sel_addr;
  assign s_raddr = sel_addr;

  assign rd_fire = (m0_gnt && m0_we == 4'h0)
                || (m1_gnt && m1_we == 4'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      pipe_v   <= '0;
      pipe_o   <= '0;
    end else begin
      if (m0_gnt || m1_gnt)
        last_gnt <= m1_gnt;
      pipe_v[0] <= rd_fire;
      pipe_o[0] <= m1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_o[i] <= pipe_o[i-1];
      end
    end
  end

  assign m0_rvalid = pipe_v[RD_LAT-1] & ~pipe_o[RD_LAT-1];
  assign m1_rvalid = pipe_v[RD_LAT-1] &  pipe_o[RD_LAT-1];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiter instances with different
// latency/priority settings, each behind a small RAM model.
module tb_mem_arbiter;

  typedef struct packed {
    int          cyc;
    logic        g0;
    logic        g1;
    logic [3:0]  we;
    logic [31:0] ra;
    logic [31:0] wd;
  } gexp_t;

  typedef struct packed {
    int          cyc;
    logic        own;
    logic [31:0] d;
  } rexp_t;

  logic        clk;
  logic        rst[3];
  logic        m0_req[3];
  logic [31:0] m0_addr[3];
  logic [31:0] m0_wdata[3];
  logic [3:0]  m0_we[3];
  logic        m0_gnt[3];
  logic [31:0] m0_rdata[3];
  logic        m0_rvalid[3];
  logic        m1_req[3];
  logic [31:0] m1_addr[3];
  logic [31:0] m1_wdata[3];
  logic [3:0]  m1_we[3];
  logic        m1_gnt[3];
  logic [31:0] m1_rdata[3];
  logic        m1_rvalid[3];
  logic [31:0] s_waddr[3];
  logic [31:0] s_wdata[3];
  logic [3:0]  s_we[3];
  logic [31:0] s_raddr[3];
  logic [31:0] s_rdata[3];

  gexp_t gq[3][$];
  rexp_t rq[3][$];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 3; i++) begin : g
    localparam int L = (i == 0) ? 1 : ((i == 1) ? 3 : 2);
    localparam int F = (i == 1) ? 1 : 0;

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .RD_LAT(L), .FIXED_PRIO(F)
    ) dut (
      .clk(clk), .rst(rst[i]),
      .m0_req(m0_req[i]), .m0_addr(m0_addr[i]),
      .m0_wdata(m0_wdata[i]), .m0_we(m0_we[i]),
      .m0_gnt(m0_gnt[i]), .m0_rdata(m0_rdata[i]),
      .m0_rvalid(m0_rvalid[i]),
      .m1_req(m1_req[i]), .m1_addr(m1_addr[i]),
      .m1_wdata(m1_wdata[i]), .m1_we(m1_we[i]),
      .m1_gnt(m1_gnt[i]), .m1_rdata(m1_rdata[i]),
      .m1_rvalid(m1_rvalid[i]),
      .s_waddr(s_waddr[i]), .s_wdata(s_wdata[i]),
      .s_we(s_we[i]), .s_raddr(s_raddr[i]),
      .s_rdata(s_rdata[i])
    );

    // RAM: unwritten words read back as C0DE_0000 + word index.
    logic [31:0] mem[64];
    logic [63:0] ok;
    logic [5:0]  ap[4];

    always @(posedge clk) begin
      ap[0] <= s_raddr[i][7:2];
      for (int k = 1; k < 4; k++) ap[k] <= ap[k-1];
      if (rst[i]) ok <= '0;
      else if (s_we[i] != 4'h0) begin
        mem[s_waddr[i][7:2]] <= s_wdata[i];
        ok[s_waddr[i][7:2]]  <= 1'b1;
      end
    end

    assign s_rdata[i] = ok[ap[L-1]] ? mem[ap[L-1]]
                      : 32'hC0DE_0000 + {26'd0, ap[L-1]};
  end

  always @(negedge clk) begin
    gexp_t       ge;
    rexp_t       re;
    logic        ev0, ev1;
    logic [31:0] ed, ad;
    if (cyc >= 1) begin
      for (int i = 0; i < 3; i++) begin
        if (gq[i].size() > 0 && gq[i][0].cyc == cyc) begin
          ge = gq[i].pop_front();
          compared++;
          if ({m0_gnt[i], m1_gnt[i], s_we[i], s_raddr[i],
               s_waddr[i], s_wdata[i]} !==
              {ge.g0, ge.g1, ge.we, ge.ra, ge.ra, ge.wd}) begin
            mismatched++;
            $display("FAIL gnt u%0d c%0d: got g=%b%b we=%h ra=%h wa=%h wd=%h want g=%b%b we=%h a=%h wd=%h",
                     i, cyc, m0_gnt[i], m1_gnt[i], s_we[i],
                     s_raddr[i], s_waddr[i], s_wdata[i],
                     ge.g0, ge.g1, ge.we, ge.ra, ge.wd);
          end
        end
        ev0 = 1'b0;
        ev1 = 1'b0;
        ed  = '0;
        if (rq[i].size() > 0 && rq[i][0].cyc == cyc) begin
          re  = rq[i].pop_front();
          ev0 = ~re.own;
          ev1 = re.own;
          ed  = re.d;
        end
        compared++;
        if ({m0_rvalid[i], m1_rvalid[i]} !== {ev0, ev1}) begin
          mismatched++;
          $display("FAIL rvalid u%0d c%0d: got %b%b want %b%b",
                   i, cyc, m0_rvalid[i], m1_rvalid[i], ev0, ev1);
        end else if (ev0 || ev1) begin
          ad = ev1 ? m1_rdata[i] : m0_rdata[i];
          compared++;
          if (ad !== ed) begin
            mismatched++;
            $display("FAIL rdata u%0d c%0d: got %h want %h",
                     i, cyc, ad, ed);
          end
        end
      end
    end
  end

  task automatic drv(
    input int          i,
    input logic        r0,
    input logic [31:0] a0,
    input logic [3:0]  w0,
    input logic [31:0] d0,
    input logic        r1,
    input logic [31:0] a1,
    input logic [3:0]  w1,
    input logic [31:0] d1,
    input logic [1:0]  eg,
    input logic [31:0] ed
  );
    gexp_t ge;
    rexp_t re;
    m0_req[i] = r0; m0_addr[i] = a0;
    m0_we[i] = w0;  m0_wdata[i] = d0;
    m1_req[i] = r1; m1_addr[i] = a1;
    m1_we[i] = w1;  m1_wdata[i] = d1;
    ge.cyc = cyc;
    ge.g0  = eg[0];
    ge.g1  = eg[1];
    ge.we  = eg[0] ? w0 : (eg[1] ? w1 : 4'h0);
    ge.ra  = eg[0] ? a0 : (eg[1] ? a1 : 32'h0);
    ge.wd  = eg[0] ? d0 : (eg[1] ? d1 : 32'h0);
    gq[i].push_back(ge);
    if (eg != 2'b00 && ge.we == 4'h0) begin
      re.cyc = cyc + lat(i);
      re.own = eg[1];
      re.d   = ed;
      rq[i].push_back(re);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) drv(i, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      m0_req[i] = 0; m0_addr[i] = 0;
      m0_we[i] = 0;  m0_wdata[i] = 0;
      m1_req[i] = 0; m1_addr[i] = 0;
      m1_we[i] = 0;  m1_wdata[i] = 0;
    end
    @(posedge clk);
    #1;
    idle(0, 2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    idle(0, 5);

    // round-robin conflict, first conflict goes to m0
    drv(0, 1, 'h40, 0, 0, 1, 'h44, 0, 0, 2'b01, 32'hC0DE0010);
    drv(0, 1, 'h40, 0, 0, 1, 'h44, 0, 0, 2'b10, 32'hC0DE0011);
    drv(0, 1, 'h40, 0, 0, 1, 'h44, 0, 0, 2'b01, 32'hC0DE0010);
    drv(0, 1, 'h40, 0, 0, 1, 'h44, 0, 0, 2'b10, 32'hC0DE0011);
    idle(0, 2);

    // write then read-back
    drv(0, 1, 'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 2'b01, 0);
    drv(0, 1, 'h10, 4'h0, 0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF);
    idle(0, 3);

    // fixed priority, RD_LAT=3
    drv(1, 1, 'h08, 0, 0, 1, 'h0C, 0, 0, 2'b01, 32'hC0DE0002);
    drv(1, 1, 'h08, 0, 0, 1, 'h0C, 0, 0, 2'b01, 32'hC0DE0002);
    drv(1, 1, 'h08, 0, 0, 1, 'h0C, 0, 0, 2'b01, 32'hC0DE0002);
    drv(1, 0, 0, 0, 0, 1, 'h0C, 0, 0, 2'b10, 32'hC0DE0003);
    idle(1, 5);
    drv(1, 0, 0, 0, 0, 1, 'h20, 0, 0, 2'b10, 32'hC0DE0008);
    idle(1, 5);
    drv(1, 0, 0, 0, 0, 1, 'h24, 4'hF, 32'h12345678, 2'b10, 0);
    drv(1, 1, 'h24, 0, 0, 0, 0, 0, 0, 2'b01, 32'h12345678);
    idle(1, 5);

    // reset while a read is in flight, RD_LAT=2
    drv(2, 1, 'h30, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    void'(rq[2].pop_back());
    rst[2] = 1'b1;
    idle(2, 2);
    rst[2] = 1'b0;
    idle(2, 3);
    drv(2, 1, 'h30, 0, 0, 1, 'h34, 0, 0, 2'b01, 32'hC0DE000C);
    drv(2, 0, 0, 0, 0, 1, 'h34, 0, 0, 2'b10, 32'hC0DE000D);
    idle(2, 4);

    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size()) > 0
           && n < 20) begin
      @(posedge clk);
      n++;
    end
    if ((rq[0].size() + rq[1].size() + rq[2].size()) > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d reads still pending, want 0",
               rq[0].size() + rq[1].size() + rq[2].size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
